// File: rtl/popcount_seq_pkg.sv
// Shared types and constants for the sequential popcount block.
package popcount_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic MODE_ONES  = 1'b0;
    localparam logic MODE_ZEROS = 1'b1;

    // Chunk index needs at least one bit even when a word is a single chunk.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/popcount_seq_chunk.sv
// Combinational set-bit counter for a W-bit slice.
module chunk_popcount #(
    parameter int W = 4
) (
    input  logic [W-1:0]           data,
    output logic [$clog2(W+1)-1:0] count
);

    localparam int CW = $clog2(W + 1);

    always_comb begin
        // NOTE: default before the loop so no path leaves count unassigned (no latch).
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(data[i]);
        end
    end

endmodule

// File: rtl/popcount_seq.sv
// Multi-cycle ones/zeros counter: CHUNK bits per clock, LSB chunk first,
// valid/ready on both sides with a single word in flight.
module popcount_seq
    import popcount_seq_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int CHUNK = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero,
    output logic             out_all
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = idx_width(N);
    localparam int PC_W  = $clog2(CHUNK + 1);

    if (WIDTH < 1 || CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_params
        $error("popcount_seq: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state, state_next;
    logic [WIDTH-1:0] shift;
    logic [CNT_W-1:0] acc, acc_next;
    logic [IDX_W-1:0] idx;
    logic             count_mode;
    logic [PC_W-1:0]  chunk_ones;
    logic             accept;
    logic             last_chunk;

    chunk_popcount #(.W(CHUNK)) u_chunk (
        .data  (shift[CHUNK-1:0]),
        .count (chunk_ones)
    );

    assign in_ready   = (state == S_IDLE) && !rst;
    assign out_valid  = (state == S_DONE);
    assign accept     = in_valid && in_ready;
    assign last_chunk = (idx == IDX_W'(N - 1));
    assign acc_next   = acc + ((count_mode == MODE_ZEROS)
                               ? CNT_W'(CHUNK) - CNT_W'(chunk_ones)
                               : CNT_W'(chunk_ones));

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (accept)     state_next = S_BUSY;
            S_BUSY:  if (last_chunk) state_next = S_DONE;
            S_DONE:  if (out_ready)  state_next = S_IDLE;
            default:                 state_next = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift      <= '0;
            acc        <= '0;
            idx        <= '0;
            count_mode <= MODE_ONES;
            out_count  <= '0;
            out_zero   <= 1'b0;
            out_all    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        shift      <= in_data;
                        count_mode <= mode;
                        acc        <= '0;
                        idx        <= '0;
                    end
                end
                S_BUSY: begin
                    acc   <= acc_next;
                    shift <= shift >> CHUNK;
                    idx   <= idx + IDX_W'(1);
                    // Result registers only move on the way into DONE.
                    if (last_chunk) begin
                        out_count <= acc_next;
                        out_zero  <= (acc_next == '0);
                        out_all   <= (acc_next == CNT_W'(WIDTH));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_seq.sv
// Self-checking bench for popcount_seq: three configurations plus the chunk counter alone.
module tb_popcount_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_pop(input logic [31:0] v, input int w);
        int n = 0;
        for (int i = 0; i < w; i++) n += int'(v[i]);
        return n;
    endfunction

    // Instance A: defaults (16/4)
    logic        a_in_valid = 0, a_in_ready, a_mode = 0, a_out_valid, a_out_ready = 1;
    logic        a_out_zero, a_out_all;
    logic [15:0] a_in_data = '0;
    logic [4:0]  a_out_count;
    // Instance B: 8/1
    logic        b_in_valid = 0, b_in_ready, b_mode = 0, b_out_valid, b_out_ready = 1;
    logic        b_out_zero, b_out_all;
    logic [7:0]  b_in_data = '0;
    logic [3:0]  b_out_count;
    // Instance C: 16/16
    logic        c_in_valid = 0, c_in_ready, c_mode = 0, c_out_valid, c_out_ready = 1;
    logic        c_out_zero, c_out_all;
    logic [15:0] c_in_data = '0;
    logic [4:0]  c_out_count;
    // Standalone chunk counter against the old 8-bit truth table
    logic [7:0]  k_data = '0;
    logic [3:0]  k_count;

    popcount_seq u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .mode(a_mode), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_count(a_out_count), .out_zero(a_out_zero),
        .out_all(a_out_all)
    );

    popcount_seq #(.WIDTH(8), .CHUNK(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .mode(b_mode), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_count(b_out_count), .out_zero(b_out_zero),
        .out_all(b_out_all)
    );

    popcount_seq #(.WIDTH(16), .CHUNK(16)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .mode(c_mode), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_count(c_out_count), .out_zero(c_out_zero),
        .out_all(c_out_all)
    );

    chunk_popcount #(.W(8)) u_k (.data(k_data), .count(k_count));

    int a_q[$];
    int b_q[$];
    int c_q[$];
    int ae, be, ce;
    int b_acc_edge = 0;
    logic b_prev_valid = 1'b0;

    // Scoreboards: pop on each output handshake, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) check("a_unexpected_out", 1, 0);
            else begin
                ae = a_q.pop_front();
                check("a_count", a_out_count, ae);
                check("a_zero", a_out_zero, ae == 0);
                check("a_all", a_out_all, ae == 16);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) b_prev_valid = 1'b0;
        else begin
            if (b_out_valid && !b_prev_valid) check("b_latency", cyc - b_acc_edge, 8);
            b_prev_valid = b_out_valid;
            if (b_in_valid && b_in_ready) b_acc_edge = cyc + 1;
            if (b_out_valid && b_out_ready) begin
                if (b_q.size() == 0) check("b_unexpected_out", 1, 0);
                else begin
                    be = b_q.pop_front();
                    check("b_count", b_out_count, be);
                    check("b_zero", b_out_zero, be == 0);
                    check("b_all", b_out_all, be == 8);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && c_out_valid && c_out_ready) begin
            if (c_q.size() == 0) check("c_unexpected_out", 1, 0);
            else begin
                ce = c_q.pop_front();
                check("c_count", c_out_count, ce);
                check("c_zero", c_out_zero, ce == 0);
                check("c_all", c_out_all, ce == 16);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_wait_ready();
        int n = 0;
        while (!a_in_ready && n < 50) begin tick(); n++; end
        if (!a_in_ready) check("a_ready_timeout", 0, 1);
    endtask

    task automatic a_wait_valid();
        int n = 0;
        while (!a_out_valid && n < 50) begin tick(); n++; end
        if (!a_out_valid) check("a_valid_timeout", 0, 1);
    endtask

    task automatic a_send(input logic [15:0] d, input logic m, input int exp, input bit track);
        a_wait_ready();
        a_in_data  = d;
        a_mode     = m;
        a_in_valid = 1'b1;
        if (track) a_q.push_back(exp);
        tick();
        a_in_valid = 1'b0;
    endtask

    task automatic drain_all();
        int n = 0;
        while ((a_q.size() + b_q.size() + c_q.size()) != 0 && n < 100) begin tick(); n++; end
        check("drain_a", a_q.size(), 0);
        check("drain_b", b_q.size(), 0);
        check("drain_c", c_q.size(), 0);
    endtask

    initial begin
        int n;
        // Reset, with a word offered on A while rst is high: rst must win.
        a_in_valid = 1'b1;
        a_in_data  = 16'hFFFF;
        repeat (3) tick();
        check("a_ready_in_rst", a_in_ready, 0);
        check("a_valid_rst", a_out_valid, 0);
        check("a_count_rst", a_out_count, 0);
        check("a_zero_rst", a_out_zero, 0);
        check("a_all_rst", a_out_all, 0);
        check("b_valid_rst", b_out_valid, 0);
        check("c_count_rst", c_out_count, 0);
        rst        = 1'b0;
        a_in_valid = 1'b0;
        #1;
        check("a_ready_after_rst", a_in_ready, 1);
        check("b_ready_after_rst", b_in_ready, 1);
        check("c_ready_after_rst", c_in_ready, 1);
        tick();
        check("a_rst_wins", a_in_ready, 1);

        for (int v = 0; v < 256; v++) begin
            k_data = v[7:0];
            #1;
            check("chunk8", k_count, ref_pop(v, 8));
        end

        // A: all ones, both modes, with latency of N=4 edges.
        a_send(16'hFFFF, 1'b0, 16, 1'b1);
        repeat (3) tick();
        check("a_lat_early", a_out_valid, 0);
        tick();
        check("a_lat", a_out_valid, 1);
        drain_all();
        a_send(16'hFFFF, 1'b1, 0, 1'b1);
        drain_all();

        // A: consumer stalls for 5 clocks.
        a_out_ready = 1'b0;
        a_send(16'hA5A5, 1'b0, 8, 1'b1);
        a_wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("a_hold_count", a_out_count, 8);
            check("a_hold_valid", a_out_valid, 1);
            check("a_hold_ready", a_in_ready, 0);
            a_in_data = 16'(a_in_data + 16'h1111);
            tick();
        end
        a_out_ready = 1'b1;
        tick();
        check("a_after_hs_valid", a_out_valid, 0);
        check("a_after_hs_ready", a_in_ready, 1);
        check("a_popped", a_q.size(), 0);

        // A: reset during the second BUSY clock discards the word.
        a_send(16'h0F0F, 1'b0, 0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("a_ready_post_abort", a_in_ready, 1);
        check("a_count_post_abort", a_out_count, 0);
        for (int i = 0; i < 6; i++) begin
            check("a_no_out", a_out_valid, 0);
            tick();
        end
        a_send(16'h0001, 1'b0, 1, 1'b1);
        drain_all();

        // A: back-to-back with in_valid and out_ready held high.
        a_wait_ready();
        a_in_data  = 16'h0003;
        a_mode     = 1'b0;
        a_in_valid = 1'b1;
        a_q.push_back(2);
        tick();
        a_in_data = 16'h0007;
        a_q.push_back(3);
        n = 0;
        while (!a_in_ready && n < 20) begin tick(); n++; end
        check("a_b2b_gap", n, 5);
        tick();
        a_in_valid = 1'b0;
        drain_all();

        // C: single-chunk word, zeros mode, inputs wiggle during DONE.
        c_out_ready = 1'b0;
        c_in_data   = 16'h8001;
        c_mode      = 1'b1;
        c_in_valid  = 1'b1;
        c_q.push_back(14);
        tick();
        c_in_valid = 1'b0;
        check("c_lat_early", c_out_valid, 0);
        tick();
        check("c_lat", c_out_valid, 1);
        for (int i = 0; i < 4; i++) begin
            c_in_data = 16'($urandom);
            c_mode    = ~c_mode;
            tick();
            check("c_hold_count", c_out_count, 14);
            check("c_hold_valid", c_out_valid, 1);
        end
        c_out_ready = 1'b1;
        drain_all();
        c_in_data  = 16'hFFFF;
        c_mode     = 1'b0;
        c_in_valid = 1'b1;
        c_q.push_back(16);
        tick();
        c_in_valid = 1'b0;
        drain_all();

        // B: full 8-bit sweep, one bit per clock, some words in zeros mode.
        for (int v = 0; v < 256; v++) begin
            n = 0;
            while (!b_in_ready && n < 50) begin tick(); n++; end
            if (!b_in_ready) check("b_ready_timeout", 0, 1);
            b_in_data  = v[7:0];
            b_mode     = (v % 17 == 0);
            b_in_valid = 1'b1;
            b_q.push_back(b_mode ? 8 - ref_pop(v, 8) : ref_pop(v, 8));
            tick();
            b_in_valid = 1'b0;
        end
        drain_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
